imem_loader: RTL

- Boot-time program loader: the writer side of the instruction memory the MIPS core reads.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues word writes at byte addresses 0, 4, 8, …, matching PC addressing.
- Holds the core (cpu_hold) until a complete image is written, then releases it and flags done.

---
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that writes a big-endian word image into the
// instruction memory from a byte stream and holds the core until it is complete.
//
// state   | meaning
// IDLE    | waiting for start, core held
// LEN_HI  | accepting word count high byte
// LEN_LO  | accepting word count low byte, range check
// DATA    | accepting the four bytes of one word
// WRITE   | single-cycle instruction memory write
// DONE    | image written, core released
// ERROR   | word count exceeded capacity, core held
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

  state_t      state;
  state_t      state_next;
  logic [7:0]  len_hi;
  logic [15:0] len_full;
  logic [15:0] remaining;
  logic [1:0]  byte_idx;
  logic [23:0] word_sr;
  logic        take;

  logic        in_ready_nxt;
  logic        mem_we_nxt;
  logic        cpu_hold_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        error_nxt;

  // in_ready is a registered copy of "next state accepts bytes", so it is
  // already valid during the first cycle of LEN_HI/LEN_LO/DATA.
  assign take     = in_valid & in_ready;
  assign len_full = {len_hi, in_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (take) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (take) begin
          if (len_full == 16'd0) begin
            state_next = S_DONE;
          end else if (len_full > DEPTH_N) begin
            state_next = S_ERROR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take && byte_idx == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (remaining == 16'd1) begin
          state_next = S_DONE;
        end else begin
          state_next = S_DATA;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt = 1'b0;
    mem_we_nxt   = 1'b0;
    cpu_hold_nxt = 1'b1;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    case (state_next)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b1;
      end
      S_WRITE: begin
        mem_we_nxt = 1'b1;
        busy_nxt   = 1'b1;
      end
      S_DONE: begin
        done_nxt     = 1'b1;
        cpu_hold_nxt = 1'b0;
      end
      S_ERROR: begin
        error_nxt = 1'b1;
      end
      default: begin
        in_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len_hi    <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word_sr   <= '0;
    end else begin
      in_ready <= in_ready_nxt;
      mem_we   <= mem_we_nxt;
      cpu_hold <= cpu_hold_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      case (state)
        S_LEN_HI: begin
          if (take) len_hi <= in_data;
        end
        S_LEN_LO: begin
          if (take && state_next == S_DATA) begin
            remaining <= len_full;
            byte_idx  <= 2'd0;
            mem_addr  <= '0;
          end
        end
        S_DATA: begin
          // The first three bytes wait in word_sr; mem_wdata only changes
          // when a whole word is ready, so it is stable throughout WRITE.
          if (take) begin
            word_sr  <= {word_sr[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) mem_wdata <= {word_sr, in_data};
          end
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + ADDR_W'(4);
          remaining <= remaining - 16'd1;
        end
        default: begin
          len_hi <= len_hi;
        end
      endcase
    end
  end

endmodule
